// File: rtl/mic_pkg.sv
// Shared definitions for the PDM microphone record/playback controller:
// the FSM state type, the sample-count width and the default parameters.
package mic_pkg;

  localparam int unsigned CNT_W          = 16;
  localparam int unsigned CLK_DIV_DEF    = 50;
  localparam int unsigned SAMPLE_MAX_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REC  = 2'd1,
    PLAY = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mic_rec_ctrl_if.sv
// Control/status bundle between the recorder controller and its user.
//   start_rec, start_play, stop : run requests (user -> controller)
//   full, empty                 : sample buffer status (user -> controller)
//   mic_clk                     : PDM microphone clock
//   wr, rd                      : sample buffer write/read strobes
//   busy, done, count           : run status and samples transferred
interface mic_rec_ctrl_if;
  import mic_pkg::*;

  logic             start_rec;
  logic             start_play;
  logic             stop;
  logic             full;
  logic             empty;
  logic             mic_clk;
  logic             wr;
  logic             rd;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;

  modport master (
    output start_rec, start_play, stop, full, empty,
    input  mic_clk, wr, rd, busy, done, count
  );

  modport slave (
    input  start_rec, start_play, stop, full, empty,
    output mic_clk, wr, rd, busy, done, count
  );

endinterface

// File: rtl/mic_clk_gen.sv
// Free-running microphone clock divider.
//   clk, reset : system clock, async active-low reset
//   mic_clk    : toggles every CLK_DIV clk cycles (period 2*CLK_DIV)
//   tick       : one-cycle strobe, high in the first cycle mic_clk is 1
module mic_clk_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  output logic mic_clk,
  output logic tick
);

  localparam int unsigned       DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0]  TERM  = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             at_term;

  assign at_term = (div_cnt == TERM);

  // Divider, clock toggle and rising-edge strobe share the same terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      mic_clk <= 1'b0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= at_term ? '0 : div_cnt + DIV_W'(1);
      if (at_term) mic_clk <= ~mic_clk;
      tick <= at_term && !mic_clk;
    end
  end

endmodule

// File: rtl/mic_rec_ctrl.sv
// Record/playback controller for a PDM microphone sample buffer.
//   clk, reset : system clock, async active-low reset
//   bus        : requests and buffer status in; mic_clk, wr/rd strobes,
//                busy, done and sample count out (all registered)
module mic_rec_ctrl
  import mic_pkg::*;
#(
  parameter int unsigned CLK_DIV    = CLK_DIV_DEF,
  parameter int unsigned SAMPLE_MAX = SAMPLE_MAX_DEF
) (
  input  logic           clk,
  input  logic           reset,
  mic_rec_ctrl_if.slave  bus
);

  localparam logic [CNT_W-1:0] SMAX = CNT_W'(SAMPLE_MAX);

  state_t           state, state_d;
  logic             tick;
  logic             wr_d, rd_d, busy_d, done_d;
  logic [CNT_W-1:0] count_d, count_inc;

  mic_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk     (clk),
    .reset   (reset),
    .mic_clk (bus.mic_clk),
    .tick    (tick)
  );

  // Saturating increment: count never wraps past SAMPLE_MAX.
  assign count_inc = (bus.count == SMAX) ? bus.count : bus.count + CNT_W'(1);

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bus.wr    <= 1'b0;
      bus.rd    <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.count <= '0;
    end else begin
      state     <= state_d;
      bus.wr    <= wr_d;
      bus.rd    <= rd_d;
      bus.busy  <= busy_d;
      bus.done  <= done_d;
      bus.count <= count_d;
    end
  end

  // Next state and next output values; stop beats a coincident tick.
  always_comb begin
    state_d = state;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    count_d = bus.count;
    case (state)
      IDLE: begin
        if (bus.start_rec) begin
          state_d = REC;
          count_d = '0;
        end else if (bus.start_play) begin
          state_d = PLAY;
          count_d = '0;
        end
      end
      REC: begin
        if (bus.stop || bus.full) begin
          state_d = DONE;
        end else if (tick) begin
          wr_d    = 1'b1;
          count_d = count_inc;
          if (count_inc == SMAX) state_d = DONE;
        end
      end
      PLAY: begin
        if (bus.stop || bus.empty) begin
          state_d = DONE;
        end else if (tick) begin
          rd_d    = 1'b1;
          count_d = count_inc;
          if (count_inc == SMAX) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == REC) || (state_d == PLAY);
    done_d = (state_d == DONE);
  end

endmodule

// File: tb/tb_mic_rec_ctrl.sv
// Scoreboard bench for mic_rec_ctrl with CLK_DIV=4, SAMPLE_MAX=8.
module tb_mic_rec_ctrl;

  localparam int CLK_DIV = 4;
  localparam int SMAX    = 8;
  localparam int PERIOD  = 2 * CLK_DIV;

  typedef struct {
    bit is_rec;
    int cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  mic_rec_ctrl_if bus ();

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_exp    = 0;
  int   n_done   = 0;

  mic_rec_ctrl #(.CLK_DIV(CLK_DIV), .SAMPLE_MAX(SMAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endfunction

  // Monitor: tracks strobes per run and checks each finished run against the queue.
  int  cyc = 0;
  int  nwr, nrd, last_strobe;
  bit  prev_busy = 1'b0;
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      prev_busy = 1'b0;
    end else begin
      if (bus.busy && !prev_busy) begin
        nwr = 0;
        nrd = 0;
        last_strobe = -1;
      end
      if (bus.wr || bus.rd) begin
        chk("wr_rd_exclusive", int'(bus.wr && bus.rd), 0);
        if (bus.wr) nwr++;
        else nrd++;
        chk("count_track", int'(bus.count), nwr + nrd);
        if (last_strobe >= 0) chk("strobe_spacing", cyc - last_strobe, PERIOD);
        last_strobe = cyc;
      end
      if (bus.done) begin
        n_done++;
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("done_count", int'(bus.count), e.cnt);
          chk("run_strobes", e.is_rec ? nwr : nrd, e.cnt);
          chk("wrong_strobe", e.is_rec ? nrd : nwr, 0);
          chk("busy_at_done", int'(bus.busy), 0);
        end
      end
      prev_busy = bus.busy;
    end
  end

  // One run; the run ends on SAMPLE_MAX, a buffer limit (kind 0) or a stop
  // coinciding with a tick (kind 1) after lim strobes.
  task automatic do_run(input bit rec, input bit both, input int lim,
                        input int kind, input bit spur);
    bit   is_rec   = rec || both;
    int   want     = (lim < SMAX) ? lim : SMAX;
    int   s        = 0;
    int   t        = 0;
    bit   seen     = 1'b0;
    bit   spur_set = 1'b0;
    bit   prev_mc;
    exp_t e;
    @(negedge clk);
    bus.start_rec  = rec || both;
    bus.start_play = !rec || both;
    e.is_rec = is_rec;
    e.cnt    = want;
    q.push_back(e);
    n_exp++;
    @(negedge clk);
    bus.start_rec  = 1'b0;
    bus.start_play = 1'b0;
    chk("busy_latency", int'(bus.busy), 1);
    while (s < lim && !seen && t < 200) begin
      @(negedge clk);
      t++;
      bus.start_rec  = 1'b0;
      bus.start_play = 1'b0;
      if (is_rec ? bus.wr : bus.rd) s++;
      if (bus.done) seen = 1'b1;
      if (spur && lim >= 2 && s == 1 && !spur_set) begin
        spur_set = 1'b1;
        if (is_rec) bus.start_play = 1'b1;
        else bus.start_rec = 1'b1;
      end
    end
    if (s < lim && !seen) chk("strobes_before_limit", s, lim);
    if (!seen && lim < SMAX) begin
      if (kind == 0) begin
        if (is_rec) bus.full = 1'b1;
        else bus.empty = 1'b1;
      end else begin
        prev_mc = bus.mic_clk;
        t = 0;
        while (t < 40) begin
          @(negedge clk);
          t++;
          if (bus.mic_clk && !prev_mc) break;
          prev_mc = bus.mic_clk;
        end
        bus.stop = 1'b1;
        @(negedge clk);
        if (bus.done) seen = 1'b1;
        bus.stop = 1'b0;
      end
    end
    t = 0;
    while (!seen && t < 50) begin
      @(negedge clk);
      t++;
      if (bus.done) seen = 1'b1;
    end
    chk("done_seen", int'(seen), 1);
    @(negedge clk);
    chk("busy_after_done", int'(bus.busy), 0);
    bus.full  = 1'b0;
    bus.empty = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got 0 expected 1 (simulation time limit)");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, s;
    bit prev_mc;
    bus.start_rec  = 1'b0;
    bus.start_play = 1'b0;
    bus.stop       = 1'b0;
    bus.full       = 1'b0;
    bus.empty      = 1'b0;

    // Reset state and mic_clk phase after release.
    repeat (10) @(negedge clk);
    chk("rst_mic_clk", int'(bus.mic_clk), 0);
    chk("rst_wr", int'(bus.wr), 0);
    chk("rst_rd", int'(bus.rd), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_count", int'(bus.count), 0);
    reset = 1'b1;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (bus.mic_clk) break;
    end
    chk("first_rise", n, CLK_DIV);
    prev_mc = bus.mic_clk;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (bus.mic_clk && !prev_mc) break;
      prev_mc = bus.mic_clk;
    end
    chk("mic_clk_period", n, PERIOD);

    // Directed runs.
    do_run(1'b1, 1'b0, 8, 0, 1'b0);   // full record to SAMPLE_MAX
    do_run(1'b1, 1'b0, 3, 0, 1'b0);   // full after 3rd wr
    do_run(1'b0, 1'b0, 5, 0, 1'b0);   // empty after 5th rd
    do_run(1'b0, 1'b1, 8, 0, 1'b1);   // both starts -> REC, start_play ignored
    do_run(1'b1, 1'b0, 4, 1, 1'b0);   // stop on the tick at count 4
    do_run(1'b0, 1'b0, 10, 0, 1'b1);  // play saturates at SAMPLE_MAX

    // Reset in the middle of playback at count 2.
    @(negedge clk);
    bus.start_play = 1'b1;
    @(negedge clk);
    bus.start_play = 1'b0;
    s = 0;
    n = 0;
    while (s < 2 && n < 100) begin
      @(negedge clk);
      n++;
      if (bus.rd) s++;
    end
    chk("play_count_before_reset", int'(bus.count), 2);
    #2 reset = 1'b0;
    #1;
    chk("async_rd", int'(bus.rd), 0);
    chk("async_busy", int'(bus.busy), 0);
    chk("async_count", int'(bus.count), 0);
    chk("async_done", int'(bus.done), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    chk("no_done_after_reset", n_done, n_exp);

    // Randomized runs.
    for (int i = 0; i < 16; i++) begin
      do_run(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
             int'($urandom_range(1, 10)), int'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
    end

    repeat (5) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    chk("done_pulses", n_done, n_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mic_rec_ctrl.md
MIC_REC_CTRL -- requirements
Module: mic_rec_ctrl

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 50, giving the clk cycles per mic_clk half-period; legal values are 2 or more.
REQ-002 The block SHALL have parameter SAMPLE_MAX, default 1024, giving the maximum samples per record or playback run; legal range is 1 to 65535.
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock. All logic SHALL be single clock domain.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start_rec, input, 1 bit: a one-cycle request to begin recording.
REQ-006 The block SHALL have port start_play, input, 1 bit: a one-cycle request to begin playback.
REQ-007 The block SHALL have port stop, input, 1 bit: a request to abort the active run.
REQ-008 The block SHALL have port full, input, 1 bit: the sample buffer is full.
REQ-009 The block SHALL have port empty, input, 1 bit: the sample buffer is empty.
REQ-010 The block SHALL have port mic_clk, output, 1 bit: the clock driven to the PDM microphone.
REQ-011 The block SHALL have port wr, output, 1 bit: the write strobe to the sample buffer (microfono wr).
REQ-012 The block SHALL have port rd, output, 1 bit: the read strobe to the sample buffer (microfono rd).
REQ-013 The block SHALL have port busy, output, 1 bit: high while in state REC or PLAY.
REQ-014 The block SHALL have port done, output, 1 bit: a one-cycle pulse when a run ends.
REQ-015 The block SHALL have port count, output, 16 bits: the number of samples transferred in the current or last run.

Function
REQ-016 mic_clk SHALL be free-running: divider counter 0..CLK_DIV-1, toggling mic_clk at terminal count, period 2*CLK_DIV clk cycles.
REQ-017 The internal strobe tick SHALL be high for exactly one clk cycle, the cycle in which mic_clk is registered 0->1.
REQ-018 The FSM SHALL have states IDLE, REC, PLAY and DONE, encoded as 2 bits.
REQ-019 In IDLE, start_rec SHALL move the FSM to REC and start_play SHALL move it to PLAY; if both are asserted together, REC wins; stop SHALL be ignored.
REQ-020 On entry to REC or PLAY, count SHALL be cleared to 0 in the same edge.
REQ-021 In REC, on each tick with full=0, wr SHALL be 1 for exactly that cycle and count SHALL increment by 1.
REQ-022 In PLAY, on each tick with empty=0, rd SHALL be 1 for exactly that cycle and count SHALL increment by 1.
REQ-023 REC SHALL move to DONE on the edge where count reaches SAMPLE_MAX, or where full=1, or where stop=1; stop has priority and SHALL suppress any wr in that cycle.
REQ-024 PLAY SHALL move to DONE under the same conditions, with empty in place of full; stop SHALL suppress any rd in that cycle.
REQ-025 DONE SHALL assert done for one cycle and then move unconditionally to IDLE.
REQ-026 start_rec and start_play SHALL be ignored in REC, PLAY and DONE, with no queuing.
REQ-027 wr and rd SHALL never both be 1; wr=0 outside REC and rd=0 outside PLAY.
REQ-028 count SHALL hold its final value in DONE and IDLE until the next run starts, and SHALL saturate at SAMPLE_MAX with no wrap.
REQ-029 All outputs SHALL be registered; latency from start_* to busy=1 SHALL be 1 cycle.

Reset
REQ-030 While reset=0, asynchronously: FSM=IDLE, divider=0, mic_clk=0, wr=0, rd=0, busy=0, done=0, count=0.
REQ-031 Reset asserted mid-run SHALL abort the run immediately, with no done pulse.
REQ-032 After reset deasserts, the first mic_clk rise SHALL occur CLK_DIV cycles later.

Structure
REQ-033 Package mic_pkg SHALL hold the state typedef (IDLE/REC/PLAY/DONE), count width 16, and default CLK_DIV and SAMPLE_MAX.
REQ-034 Sub-module mic_clk_gen SHALL contain the divider, mic_clk and tick; the FSM, strobes and counter SHALL live in the top level.

Verification (CLK_DIV=4, SAMPLE_MAX=8)
REQ-035 Reset: hold reset=0 for 10 cycles -> all outputs 0; mic_clk first rises 4 cycles after release, with period 8.
REQ-036 Full record: pulse start_rec with full=0 -> busy=1 next cycle; 8 wr pulses 8 cycles apart; then done pulse, count=8, busy=0.
REQ-037 Buffer limits: raise full after the 3rd wr -> no further wr, done, count=3; play with empty raised after the 5th rd -> count=5.
REQ-038 Contention: start_rec and start_play in the same cycle -> REC, rd stays 0; start_play during REC is ignored.
REQ-039 Abort: stop coinciding with a tick at count=4 -> no wr that cycle, done, count=4.
REQ-040 Reset mid-PLAY at count=2 -> rd, busy and count go to 0 asynchronously; no done pulse.
